// File: rtl/chess_clock_ctrl.sv
// Two-player chess-clock controller: holds both remaining times,
// switches the running side on move, handles pause/resume and flag fall.
// Ports:
//   clkIn, reset            - clock, synchronous active-high reset
//   tick                    - one-cycle 1 Hz pulse from the divider
//   btnA, btnB              - move buttons (debounced levels)
//   btnStart, btnPause      - start/resume/reload and pause (levels)
//   divEnable, running      - high while a clock is running
//   timeA, timeB            - remaining seconds per player
//   turnA                   - 1 = A selected (also saved turn when paused)
//   flagA, flagB            - time expired
module chess_clock_ctrl #(
    parameter int unsigned INIT_SEC = 300,
    parameter int unsigned INC_SEC  = 0,
    parameter int unsigned MAX_SEC  = 5999
) (
    input  logic        clkIn,
    input  logic        reset,
    input  logic        tick,
    input  logic        btnA,
    input  logic        btnB,
    input  logic        btnStart,
    input  logic        btnPause,
    output logic        divEnable,
    output logic [12:0] timeA,
    output logic [12:0] timeB,
    output logic        turnA,
    output logic        running,
    output logic        flagA,
    output logic        flagB
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_A,
        S_RUN_B,
        S_PAUSED,
        S_FLAG
    } state_t;

    localparam logic [12:0] INIT_T = 13'(INIT_SEC);
    localparam logic [13:0] INC_T  = 14'(INC_SEC);
    localparam logic [13:0] MAX_T  = 14'(MAX_SEC);

    state_t      state_q, state_d;
    logic [12:0] time_a_q, time_a_d;
    logic [12:0] time_b_q, time_b_d;
    logic        turn_a_q, turn_a_d;
    logic        flag_a_q, flag_a_d;
    logic        flag_b_q, flag_b_d;
    logic        run_q, run_d;
    logic [3:0]  prev_q, prev_d;

    logic [3:0]  ev;
    logic        ev_a, ev_b, ev_start, ev_pause;
    logic        side_a;
    logic [12:0] own_t, dec_t, inc_t, new_t;
    logic [13:0] sum_t;
    logic        own_ev, expire;

    // Previous-value registers turn level inputs into one-cycle events.
    assign prev_d   = {btnPause, btnStart, btnB, btnA};
    assign ev       = prev_d & ~prev_q;
    assign ev_a     = ev[0];
    assign ev_b     = ev[1];
    assign ev_start = ev[2];
    assign ev_pause = ev[3];

    // Arithmetic on whichever side is currently running.
    assign side_a = (state_q == S_RUN_A);
    assign own_t  = side_a ? time_a_q : time_b_q;
    assign own_ev = side_a ? ev_a : ev_b;
    assign dec_t  = own_t - {12'd0, tick};
    assign sum_t  = {1'b0, dec_t} + INC_T;
    assign inc_t  = (sum_t > MAX_T) ? MAX_T[12:0] : sum_t[12:0];
    assign expire = tick && (own_t == 13'd1);

    always_comb begin
        state_d  = state_q;
        time_a_d = time_a_q;
        time_b_d = time_b_q;
        turn_a_d = turn_a_q;
        flag_a_d = flag_a_q;
        flag_b_d = flag_b_q;
        new_t    = dec_t;
        case (state_q)
            S_IDLE: begin
                if (ev_start) begin
                    state_d  = S_RUN_A;
                    turn_a_d = 1'b1;
                end
            end
            S_RUN_A, S_RUN_B: begin
                if (expire) begin
                    // Flag fall swallows every other event this cycle.
                    new_t   = 13'd0;
                    state_d = S_FLAG;
                    if (side_a) flag_a_d = 1'b1;
                    else        flag_b_d = 1'b1;
                end else if (ev_pause) begin
                    state_d = S_PAUSED;
                end else if (own_ev) begin
                    new_t    = inc_t;
                    state_d  = side_a ? S_RUN_B : S_RUN_A;
                    turn_a_d = ~side_a;
                end
                if (side_a) time_a_d = new_t;
                else        time_b_d = new_t;
            end
            S_PAUSED: begin
                if (ev_start) state_d = turn_a_q ? S_RUN_A : S_RUN_B;
            end
            S_FLAG: begin
                if (ev_start) begin
                    state_d  = S_IDLE;
                    time_a_d = INIT_T;
                    time_b_d = INIT_T;
                    flag_a_d = 1'b0;
                    flag_b_d = 1'b0;
                    turn_a_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        run_d = (state_d == S_RUN_A) || (state_d == S_RUN_B);
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state_q  <= S_IDLE;
            time_a_q <= INIT_T;
            time_b_q <= INIT_T;
            turn_a_q <= 1'b1;
            flag_a_q <= 1'b0;
            flag_b_q <= 1'b0;
            run_q    <= 1'b0;
            // Held buttons must not fire an event right after reset.
            prev_q   <= 4'hF;
        end else begin
            state_q  <= state_d;
            time_a_q <= time_a_d;
            time_b_q <= time_b_d;
            turn_a_q <= turn_a_d;
            flag_a_q <= flag_a_d;
            flag_b_q <= flag_b_d;
            run_q    <= run_d;
            prev_q   <= prev_d;
        end
    end

    assign divEnable = run_q;
    assign running   = run_q;
    assign timeA     = time_a_q;
    assign timeB     = time_b_q;
    assign turnA     = turn_a_q;
    assign flagA     = flag_a_q;
    assign flagB     = flag_b_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Self-checking bench for chess_clock_ctrl: directed scenarios plus
// randomized play compared against a behavioural game model.
module tb_chess_clock_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        btnA = 1'b0, btnB = 1'b0;
    logic        btnStart = 1'b0, btnPause = 1'b0;
    logic        divEnable, running, turnA, flagA, flagB;
    logic [12:0] timeA, timeB;

    logic        s_div, s_run, s_turn, s_fa, s_fb;
    logic [12:0] s_ta, s_tb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chess_clock_ctrl #(.INIT_SEC(3), .INC_SEC(2), .MAX_SEC(5999)) u_dut (
        .clkIn(clk), .reset(reset), .tick(tick),
        .btnA(btnA), .btnB(btnB), .btnStart(btnStart), .btnPause(btnPause),
        .divEnable(divEnable), .timeA(timeA), .timeB(timeB),
        .turnA(turnA), .running(running), .flagA(flagA), .flagB(flagB)
    );

    chess_clock_ctrl #(.INIT_SEC(5995), .INC_SEC(10), .MAX_SEC(5999)) u_sat (
        .clkIn(clk), .reset(reset), .tick(tick),
        .btnA(btnA), .btnB(btnB), .btnStart(btnStart), .btnPause(btnPause),
        .divEnable(s_div), .timeA(s_ta), .timeB(s_tb),
        .turnA(s_turn), .running(s_run), .flagA(s_fa), .flagB(s_fb)
    );

    logic [30:0] obs;
    assign obs = {running, divEnable, turnA, flagA, flagB, timeA, timeB};

    // Behavioural game model (main DUT: INIT 3, INC 2, MAX 5999).
    localparam int M_INIT = 3, M_INC = 2, M_MAX = 5999;
    bit m_run, m_pause, m_flagged, m_turn, m_fa, m_fb;
    int m_ta, m_tb;
    bit pa, pb, ps, pp;

    function automatic logic [30:0] expv(bit r, bit t, bit fa, bit fb,
                                         int ta, int tb);
        return {r, r, t, fa, fb, 13'(ta), 13'(tb)};
    endfunction

    function automatic logic [30:0] model_vec();
        return expv(m_run, m_turn, m_fa, m_fb, m_ta, m_tb);
    endfunction

    task automatic model_reset();
        m_run = 0; m_pause = 0; m_flagged = 0; m_turn = 1;
        m_fa = 0; m_fb = 0; m_ta = M_INIT; m_tb = M_INIT;
        pa = 1; pb = 1; ps = 1; pp = 1;
    endtask

    task automatic model_step(bit a, bit b, bit s, bit p, bit t);
        bit ea, eb, es, ep, mine;
        int own;
        ea = a && !pa; eb = b && !pb; es = s && !ps; ep = p && !pp;
        if (m_flagged) begin
            if (es) begin
                m_flagged = 0; m_fa = 0; m_fb = 0; m_turn = 1;
                m_ta = M_INIT; m_tb = M_INIT;
            end
        end else if (m_pause) begin
            if (es) begin m_pause = 0; m_run = 1; end
        end else if (m_run) begin
            own  = m_turn ? m_ta : m_tb;
            mine = m_turn ? ea : eb;
            if (t && own == 1) begin
                own = 0; m_run = 0; m_flagged = 1;
                if (m_turn) m_fa = 1; else m_fb = 1;
            end else begin
                own = own - int'(t);
                if (ep) begin
                    m_run = 0; m_pause = 1;
                end else if (mine) begin
                    own = (own + M_INC > M_MAX) ? M_MAX : own + M_INC;
                end
            end
            if (m_turn) m_ta = own; else m_tb = own;
            if (m_run && !ep && mine && !(t && own == 0)) m_turn = !m_turn;
        end else begin
            if (es) begin m_run = 1; m_turn = 1; end
        end
        pa = a; pb = b; ps = s; pp = p;
    endtask

    task automatic cyc(bit a, bit b, bit s, bit p, bit t);
        btnA = a; btnB = b; btnStart = s; btnPause = p; tick = t;
        @(posedge clk);
        model_step(a, b, s, p, t);
        #1;
    endtask

    task automatic do_reset(bit start_held);
        reset = 1; btnStart = start_held;
        btnA = 0; btnB = 0; btnPause = 0; tick = 0;
        @(posedge clk);
        model_reset();
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset(0);
        checks++;
        if (obs !== expv(0, 1, 0, 0, 3, 3)) begin
            errors++;
            $display("FAIL reset: got %h want %h", obs, expv(0, 1, 0, 0, 3, 3));
        end
    endtask

    task automatic test_start();
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (obs !== expv(0, 1, 0, 0, 3, 3)) begin
            errors++;
            $display("FAIL idle_tick: got %h want %h", obs, expv(0, 1, 0, 0, 3, 3));
        end
        cyc(0, 0, 1, 0, 0);
        checks++;
        if (obs !== expv(1, 1, 0, 0, 3, 3)) begin
            errors++;
            $display("FAIL start: got %h want %h", obs, expv(1, 1, 0, 0, 3, 3));
        end
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_move();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (obs !== expv(1, 1, 0, 0, 1, 3)) begin
            errors++;
            $display("FAIL back_to_back_ticks: got %h want %h", obs, expv(1, 1, 0, 0, 1, 3));
        end
        cyc(0, 1, 1, 0, 0);
        checks++;
        if (obs !== expv(1, 1, 0, 0, 1, 3)) begin
            errors++;
            $display("FAIL other_move_ignored: got %h want %h", obs, expv(1, 1, 0, 0, 1, 3));
        end
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (obs !== expv(1, 0, 0, 0, 3, 3)) begin
            errors++;
            $display("FAIL move_a: got %h want %h", obs, expv(1, 0, 0, 0, 3, 3));
        end
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (obs !== expv(1, 0, 0, 0, 3, 3)) begin
            errors++;
            $display("FAIL held_button: got %h want %h", obs, expv(1, 0, 0, 0, 3, 3));
        end
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_flag();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        checks++;
        if (obs !== expv(0, 0, 0, 1, 3, 0)) begin
            errors++;
            $display("FAIL flag_b: got %h want %h", obs, expv(0, 0, 0, 1, 3, 0));
        end
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 1);
        checks++;
        if (obs !== expv(0, 0, 0, 1, 3, 0)) begin
            errors++;
            $display("FAIL flag_frozen: got %h want %h", obs, expv(0, 0, 0, 1, 3, 0));
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        checks++;
        if (obs !== expv(0, 1, 0, 0, 3, 3)) begin
            errors++;
            $display("FAIL flag_reload: got %h want %h", obs, expv(0, 1, 0, 0, 3, 3));
        end
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_pause();
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (obs !== expv(0, 0, 0, 0, 5, 3)) begin
            errors++;
            $display("FAIL pause: got %h want %h", obs, expv(0, 0, 0, 0, 5, 3));
        end
        for (int i = 0; i < 5; i++) cyc(i[0], !i[0], 0, 0, 1);
        checks++;
        if (obs !== expv(0, 0, 0, 0, 5, 3)) begin
            errors++;
            $display("FAIL paused_ticks: got %h want %h", obs, expv(0, 0, 0, 0, 5, 3));
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        checks++;
        if (obs !== expv(1, 0, 0, 0, 5, 3)) begin
            errors++;
            $display("FAIL resume_b: got %h want %h", obs, expv(1, 0, 0, 0, 5, 3));
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 1);
        checks++;
        if (obs !== expv(0, 0, 0, 0, 5, 2)) begin
            errors++;
            $display("FAIL pause_beats_move: got %h want %h", obs, expv(0, 0, 0, 0, 5, 2));
        end
    endtask

    task automatic test_reset_mid();
        do_reset(0);
        checks++;
        if (obs !== expv(0, 1, 0, 0, 3, 3)) begin
            errors++;
            $display("FAIL reset_mid: got %h want %h", obs, expv(0, 1, 0, 0, 3, 3));
        end
    endtask

    task automatic test_reset_held();
        do_reset(1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        checks++;
        if (obs !== expv(0, 1, 0, 0, 3, 3)) begin
            errors++;
            $display("FAIL start_held: got %h want %h", obs, expv(0, 1, 0, 0, 3, 3));
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        checks++;
        if (obs !== expv(1, 1, 0, 0, 3, 3)) begin
            errors++;
            $display("FAIL start_after_release: got %h want %h", obs, expv(1, 1, 0, 0, 3, 3));
        end
    endtask

    task automatic test_saturate();
        do_reset(0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (s_ta !== 13'd5999 || s_turn !== 1'b0 || s_run !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got timeA=%0d turnA=%0d run=%0d want 5999 0 1",
                     s_ta, s_turn, s_run);
        end
    endtask

    task automatic test_random();
        bit a, b, s, p, t;
        int bad;
        bad = 0;
        do_reset(0);
        for (int i = 0; i < 4000; i++) begin
            a = ($urandom_range(0, 4) == 0);
            b = ($urandom_range(0, 4) == 0);
            s = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 2) == 0);
            cyc(a, b, s, p, t);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random cyc %0d: got %h want %h", i, obs, model_vec());
                bad++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_move();
        test_flag();
        test_pause();
        test_reset_mid();
        test_reset_held();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chess_clock_ctrl.md
# chess_clock_ctrl

Two-player chess-clock controller for the Nexys 4 chess timer. It holds both players' remaining time, switches the running clock when a player presses their move button, and handles pause/resume and flag fall. It gates the frequency divider through `divEnable` and consumes the divider's once-per-second `tick` pulse. Its outputs feed the display formatter.

## Interface
Parameters:
- `INIT_SEC`, default 300: starting time per player, in seconds. Legal range 1..5999.
- `INC_SEC`, default 0: Fischer increment, in seconds, added after each completed move.
- `MAX_SEC`, default 5999: saturation limit for a time value (99:59).

Ports:
- `clkIn`  in  1  system clock (100 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle pulse, one per second, from the frequency divider.
- `btnA`  in  1  player A move button; debounced, synchronous level.
- `btnB`  in  1  player B move button; debounced, synchronous level.
- `btnStart`  in  1  start/resume/reload; debounced level.
- `btnPause`  in  1  pause; debounced level.
- `divEnable`  out  1  enable to the frequency divider.
- `timeA`  out  13  player A remaining seconds, unsigned binary.
- `timeB`  out  13  player B remaining seconds, unsigned binary.
- `turnA`  out  1  1 = A's clock is selected, 0 = B's.
- `running`  out  1  high in RUN_A or RUN_B.
- `flagA`  out  1  A's time expired.
- `flagB`  out  1  B's time expired.

## Operation
- **States:** IDLE, RUN_A, RUN_B, PAUSED, FLAG. `turnA` doubles as the saved turn while in PAUSED.
- **Edge detection:** each button has a previous-value register. An event is `btn & ~prev`. All logic acts on events, never on levels.
- **IDLE:**
  - `timeA` = `timeB` = `INIT_SEC`.
  - A start event goes to RUN_A; A always moves first.
  - All other inputs, including `tick`, are ignored.
- **RUN_A:** the actions below are evaluated in this priority order, all in the same cycle.
  1. A `tick` decrements `timeA`.
  2. If `tick` arrives and `timeA` == 1: `timeA` becomes 0, `flagA` goes to 1, state goes to FLAG. Any other event in that cycle is dropped.
  3. Otherwise, a pause event goes to PAUSED. A move event in the same cycle is dropped.
  4. Otherwise, a `btnA` event sets `timeA` to (`timeA` − tick + `INC_SEC`), saturated at `MAX_SEC`. State goes to RUN_B and `turnA` goes to 0.
  5. A `btnB` event is ignored. A start event is ignored.
- **RUN_B:** mirror of RUN_A, using `timeB`, `btnB` and `flagB`. A `btnB` event goes to RUN_A and sets `turnA` to 1.
- **PAUSED:**
  - `tick` and both move buttons are ignored.
  - A start event returns to RUN_A if `turnA`=1, otherwise to RUN_B.
  - A pause event is ignored.
- **FLAG:**
  - Times and flags are frozen.
  - A start event reloads both times to `INIT_SEC`, clears both flags, sets `turnA` to 1 and goes to IDLE.
  - All other inputs are ignored.
- **Outputs:** `divEnable` = `running` = (state is RUN_A or RUN_B). All outputs are registered.
- **Arithmetic:**
  - Time registers are 13-bit unsigned.
  - A decrement never goes below 0, because expiry catches the 1→0 step.
  - An increment is computed at 14 bits and then clamped to `MAX_SEC`.

## Timing
- **Reset values:**
  - State IDLE; `timeA` = `timeB` = `INIT_SEC`; `turnA`=1.
  - `divEnable`=0, `running`=0, `flagA`=0, `flagB`=0.
  - All button previous-value registers = 1, so a button held through reset does not produce an event.
- **Reset mid-game:** reset overrides everything on the next edge and produces the values above.
- **Latency:** an event sampled at edge k updates state and outputs at edge k; they are visible after that edge.
  - `divEnable` rises on the same edge that enters RUN_x.
  - The first `tick` can follow at any later cycle.
- **Simultaneous tick and own move:** both take effect in one cycle, giving a net change of `INC_SEC` − 1.
- **Button width:** a held button produces exactly one event. A new event requires the input to be released for at least one cycle.
- **Tick width:** `tick` must be exactly one cycle wide. Back-to-back ticks each decrement once.

## Test plan
Directed scenarios, using `INIT_SEC`=3, `INC_SEC`=2 unless stated otherwise:
- Reset, then a start event → RUN_A, `divEnable`=1, `turnA`=1, `timeA`=3, `timeB`=3.
- In RUN_A, 2 ticks → `timeA`=1; then a `btnA` event → `timeA`=3, state RUN_B, `turnA`=0; a `btnB` event in RUN_A is ignored.
- In RUN_B with `timeB`=1, `tick` and a `btnB` event in the same cycle → `timeB`=0, `flagB`=1, FLAG, `divEnable`=0; a later `btnB` event changes nothing.
- From RUN_B, a pause event → PAUSED, `running`=0; 5 ticks leave both times unchanged; a start event → RUN_B.
- `INC_SEC`=10, `timeA`=5995, a `btnA` event with no tick → `timeA`=5999 (saturated).
- In FLAG, a start event → IDLE, both times = 3, flags = 0; `btnStart` held high through reset → no event, state stays IDLE.
